seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Inverse of the team's 7-segment digit encoder.
- Samples a multiplexed 7-segment bus, qualifying each pattern with a one-hot digit-select strobe. Decodes each stable pattern back to a 4-bit value and emits a complete frame of DIGITS nibbles with a one-cycle valid pulse.
- Used as a loopback/monitor on the display path so benches and self-test logic can read back what the panel shows.

Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern (2..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- is_hex  in  1  1 = hex encoding table, 0 = decimal encoding table.
- seg_in  in  7  segment lines, asynchronous to clk.
- dig_sel  in  DIGITS  digit strobe, one-hot active-high; bit i = position i. Asynchronous to clk.
- digits_out  out  4*DIGITS  decoded frame; nibble i at [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when digits_out updates.
- frame_err  out  1  valid with frame_valid; 1 if any position held an undecodable pattern.
- blank_out  out  DIGITS  per-position blank flags (see Optional Feature).

Behaviour:
- Reset: all outputs and internal state go to 0 immediately on rst_n low.
- Input synchronisation:
  - seg_in and dig_sel each pass through 2 flops before use.
  - is_hex is sampled directly; it is quasi-static.
- Hex table (seg[6:0], bit0 = a ... bit6 = g): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:73.
- Decimal table (seg[6:0], bit6 = a ... bit0 = g): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:73. Digits A-F do not exist in decimal mode.
- Any pattern not in the active table is an error pattern. The nibble recorded for it is 0 and the error bit is set.
- Stability counter:
  - Counts synchronised samples where {seg, dig_sel} equals the previous sample and dig_sel is one-hot.
  - Resets to 0 on any change, or when dig_sel is zero or multi-hot.
  - Saturates at STABLE_CYCLES-1.
- Capture:
  - The cycle the counter reaches STABLE_CYCLES-1, the position decodes once: nibble, error bit and blank bit go into slot i, and captured[i] is set.
  - A position does not re-capture until its pattern changes or its strobe drops.
  - A re-capture of an already-captured position in the same frame overwrites that slot.
- Frame completion:
  - The cycle after captured becomes all-ones, frame_valid pulses for 1 cycle.
  - digits_out and blank_out load from the slots; frame_err = OR of slot error bits.
  - captured and error bits clear in that same cycle.
- Outputs hold between frames.
- Latency: an input change reaches frame_valid no earlier than 2 (sync) + STABLE_CYCLES + 1 cycles after the last position becomes stable.
- is_hex toggle: clears captured, the stability counter and the slot error bits in the cycle it is seen. The frame restarts and no frame_valid is issued for the partial frame.
- If capture of the last position and an is_hex toggle coincide, the toggle wins: no pulse.
- dig_sel all-zero (blanking gap between strobes) is legal and only resets the counter.

Optional Feature:
- Macro: SEG_SCAN_DECODER_BLANK_EN.
- Defined:
  - Pattern 0x00 is a legal blank in both modes: nibble 0, error bit 0, blank bit 1.
  - blank_out reports per-position blanks at frame_valid.
- Undefined:
  - 0x00 is an error pattern.
  - blank_out is tied to 0.

Test Plan:
- Hex, DIGITS=4: strobe positions 0..3 with 3F, 06, 5B, 4F for 8 cycles each → one frame_valid, digits_out=16'h3210, frame_err=0.
- Decimal: strobe 7E, 30, 73, 7F → digits_out=16'h8910, frame_err=0. Same patterns in hex mode → frame_err=1, since 7E/30 are undecodable.
- Glitch: position 1 pattern changes every 2 cycles with STABLE_CYCLES=4 → no capture and no frame_valid until held for ≥4 synced cycles.
- Multi-hot dig_sel=4'b0011 held for 20 cycles → no capture; counter stays 0.
- is_hex toggled after 3 positions captured → no pulse; a full 4-position re-scan then yields exactly one frame_valid.
- seg_in=00 on position 2: with macro → blank_out=4'b0100, frame_err=0; without macro → frame_err=1. Assert rst_n mid-frame → all outputs 0 asynchronously, next frame needs all 4 positions again.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed 7-segment bus.
// Each digit position is qualified by a one-hot strobe. A pattern must be
// stable for STABLE_CYCLES synchronised samples before it is decoded to a
// nibble. Once every position has been captured, the complete frame is
// published with a one-cycle frame_valid pulse.
// Optional feature macro: SEG_SCAN_DECODER_BLANK_EN. When it is defined,
// pattern 0x00 decodes as a legal blank and is reported on blank_out.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_hex,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [DIGITS-1:0]     blank_out
);

`ifdef SEG_SCAN_DECODER_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  // Decode one pattern to {blank, err, nibble}. An unknown pattern yields nibble 0 with err set.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg, input logic hex);
    logic [5:0] r;
    r = {1'b0, 1'b1, 4'h0};
    if (hex) begin
      case (seg)
        7'h3F: r = {2'b00, 4'h0};
        7'h06: r = {2'b00, 4'h1};
        7'h5B: r = {2'b00, 4'h2};
        7'h4F: r = {2'b00, 4'h3};
        7'h66: r = {2'b00, 4'h4};
        7'h6D: r = {2'b00, 4'h5};
        7'h7D: r = {2'b00, 4'h6};
        7'h07: r = {2'b00, 4'h7};
        7'h7F: r = {2'b00, 4'h8};
        7'h6F: r = {2'b00, 4'h9};
        7'h77: r = {2'b00, 4'hA};
        7'h7C: r = {2'b00, 4'hB};
        7'h39: r = {2'b00, 4'hC};
        7'h5E: r = {2'b00, 4'hD};
        7'h79: r = {2'b00, 4'hE};
        7'h73: r = {2'b00, 4'hF};
        default: r = {2'b01, 4'h0};
      endcase
    end else begin
      case (seg)
        7'h7E: r = {2'b00, 4'h0};
        7'h30: r = {2'b00, 4'h1};
        7'h6D: r = {2'b00, 4'h2};
        7'h79: r = {2'b00, 4'h3};
        7'h33: r = {2'b00, 4'h4};
        7'h5B: r = {2'b00, 4'h5};
        7'h5F: r = {2'b00, 4'h6};
        7'h70: r = {2'b00, 4'h7};
        7'h7F: r = {2'b00, 4'h8};
        7'h73: r = {2'b00, 4'h9};
        default: r = {2'b01, 4'h0};
      endcase
    end
    if (BLANK_EN && (seg == 7'h00)) begin
      r = {2'b10, 4'h0};
    end else begin
      r = r;
    end
    return r;
  endfunction

  logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
  logic [DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
  logic                hex_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   captured_q, captured_d;
  logic [4*DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                fv_q, fv_d;
  logic                ferr_q, ferr_d;

  logic                sel_onehot_s, same_s, toggle_s, cap_s, complete_s;
  logic [5:0]          dec_s;

  // Two-flop synchronisers for the asynchronous bus, plus the previous sample and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= 7'h00;
      seg_s2_q   <= 7'h00;
      seg_prev_q <= 7'h00;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      sel_prev_q <= '0;
      hex_q      <= 1'b0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      sel_s1_q   <= dig_sel;
      sel_s2_q   <= sel_s1_q;
      sel_prev_q <= sel_s2_q;
      hex_q      <= is_hex;
    end
  end

  // Stability counting, capture into slots and frame completion.
  always_comb begin
    sel_onehot_s = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - 1'b1)) == '0);
    same_s       = (seg_s2_q == seg_prev_q) && (sel_s2_q == sel_prev_q);
    toggle_s     = (is_hex != hex_q);
    dec_s        = decode_seg(seg_s2_q, is_hex);
    // A mode toggle restarts the frame and overrides both capture and completion.
    cap_s        = !toggle_s && sel_onehot_s && same_s && (cnt_q == CNT_MAX - 8'd1);
    complete_s   = !toggle_s && (captured_q == {DIGITS{1'b1}});

    cnt_d        = 8'd0;
    captured_d   = captured_q;
    slot_nib_d   = slot_nib_q;
    slot_err_d   = slot_err_q;
    slot_blank_d = slot_blank_q;
    digits_d     = digits_q;
    blank_d      = blank_q;
    ferr_d       = ferr_q;
    fv_d         = complete_s;

    if (toggle_s) begin
      cnt_d      = 8'd0;
      captured_d = '0;
      slot_err_d = '0;
    end else if (sel_onehot_s && same_s) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + 8'd1);
    end else begin
      cnt_d = 8'd0;
    end

    if (complete_s) begin
      digits_d   = slot_nib_q;
      blank_d    = slot_blank_q;
      ferr_d     = |slot_err_q;
      captured_d = '0;
      slot_err_d = '0;
    end else begin
      fv_d = 1'b0;
    end

    if (cap_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_s2_q[i]) begin
          slot_nib_d[4*i +: 4] = dec_s[3:0];
          slot_err_d[i]        = dec_s[4];
          slot_blank_d[i]      = dec_s[5];
          captured_d[i]        = 1'b1;
        end else begin
          slot_nib_d[4*i +: 4] = slot_nib_d[4*i +: 4];
        end
      end
    end else begin
      captured_d = captured_d;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 8'd0;
      captured_q   <= '0;
      slot_nib_q   <= '0;
      slot_err_q   <= '0;
      slot_blank_q <= '0;
      digits_q     <= '0;
      blank_q      <= '0;
      fv_q         <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      slot_nib_q   <= slot_nib_d;
      slot_err_q   <= slot_err_d;
      slot_blank_q <= slot_blank_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      fv_q         <= fv_d;
      ferr_q       <= ferr_d;
    end
  end

  assign digits_out  = digits_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign blank_out   = blank_q;

endmodule
